toggle_monitor: RTL
===================

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of edge and run-length counters.
REQ-002 Parameter EXP_RUN, default 1: expected cycles between consecutive input edges.
REQ-003 Parameter LOCK_N, default 4: consecutive matching runs required to declare lock.
REQ-004 Parameter TIMEOUT, default 8: cycles without an edge that constitute a stall; TIMEOUT > EXP_RUN.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_sig  input  1  monitored toggle signal from the upstream toggle stage, already in clk domain.
REQ-008 clr  input  1  synchronous clear of counters, error and FSM.
REQ-009 edge_cnt  output  CNT_W  total edges seen since reset/clr, saturating.
REQ-010 run_len  output  CNT_W  length in cycles of the most recently completed run.
REQ-011 locked  output  1  high while FSM is LOCKED.
REQ-012 err  output  1  high while FSM is ERROR (sticky).
REQ-013 err_code  output  2  00 none, 01 wrong run length, 10 stall timeout; 00 outside ERROR.

Function
REQ-014 in_q SHALL register in_sig every cycle, including in ERROR and during clr.
REQ-015 edge SHALL be (in_sig != in_q), combinational, same cycle as the input change.
REQ-016 run_cnt SHALL load 1 on edge, else increment, saturating at all-ones.
REQ-017 On edge, run_len SHALL load the current run_cnt and edge_cnt SHALL increment (saturating at 2^CNT_W-1); both visible the cycle after the edge.
REQ-018 FSM states SHALL be IDLE, TRACK, LOCKED, ERROR.
REQ-019 IDLE: first edge -> TRACK, run not checked; timeout ignored.
REQ-020 TRACK: edge with run_cnt == EXP_RUN increments match_cnt; when match_cnt reaches LOCK_N -> LOCKED; edge with run_cnt != EXP_RUN -> ERROR, code 01.
REQ-021 TRACK/LOCKED: run_cnt == TIMEOUT with no edge in that cycle -> ERROR, code 10.
REQ-022 LOCKED: edge with run_cnt != EXP_RUN -> ERROR, code 01; matching edges stay LOCKED.
REQ-023 ERROR SHALL persist, with err_code and run_len frozen, until clr or rst; edge_cnt keeps counting.
REQ-024 clr SHALL force IDLE, zero edge_cnt, run_len, run_cnt, match_cnt and err_code; clr wins over a simultaneous edge or error.
REQ-025 All outputs SHALL be registered; locked/err/err_code change the cycle after the triggering condition.

Reset
REQ-026 rst SHALL take priority over clr and set state IDLE, in_q 0, all counters 0, all outputs 0.
REQ-027 rst asserted mid-run SHALL discard all progress; the first post-reset cycle with in_sig=1 counts as an edge.

Structure
REQ-028 Package toggle_mon_pkg SHALL hold the FSM state enum and the err_code enum/constants.
REQ-029 One sub-module, toggle_mon_edge, SHALL hold in_q and produce edge; counters and FSM live in toggle_monitor.

Verification (EXP_RUN=1, LOCK_N=4, TIMEOUT=8 unless stated)
REQ-030 rst high 3 cycles, in_sig=0 -> edge_cnt=0, run_len=0, locked=0, err=0, err_code=00.
REQ-031 in_sig toggles every cycle for 10 edges -> locked=1 the cycle after the 5th edge, edge_cnt=10, run_len=1, err=0.
REQ-032 After lock, hold in_sig constant from the last edge -> err=1, err_code=10, locked=0 on the 9th cycle after that edge.
REQ-033 After lock, one run of 2 cycles -> err=1, err_code=01, run_len=2 the cycle after the offending edge.
REQ-034 In ERROR, clr asserted on an edge cycle -> next cycle err=0, err_code=00, edge_cnt=0, locked=0, state IDLE.
REQ-035 CNT_W=4, 20 edges at one-cycle runs -> edge_cnt holds 15; rst mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/toggle_mon_pkg.sv
// ============================================================================
// toggle_mon_pkg : FSM state and error-code types shared by the toggle monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package toggle_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_ERROR  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_RUN   = 2'b01,
      ERR_STALL = 2'b10
   } err_code_e;

endpackage

`default_nettype wire

// File: rtl/toggle_mon_edge.sv
// ============================================================================
// toggle_mon_edge : registers the monitored signal and flags any change
// Rev 1.0
// ============================================================================
`default_nettype none

module toggle_mon_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic edge_o
);

   logic sig_q;

   // Keeps sampling through clr and ERROR so edge detection never goes stale.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign edge_o = sig_i ^ sig_q;

endmodule

`default_nettype wire

// File: rtl/toggle_monitor.sv
// ============================================================================
// toggle_monitor : measures run lengths of a toggling signal, locks onto the
//                  expected cadence and flags wrong runs or stalls (sticky)
// Rev 1.0
// ============================================================================
`default_nettype none

module toggle_monitor
   import toggle_mon_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned EXP_RUN = 1,
   parameter int unsigned LOCK_N  = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_sig,
   input  logic             clr,
   output logic [CNT_W-1:0] edge_cnt,
   output logic [CNT_W-1:0] run_len,
   output logic             locked,
   output logic             err,
   output logic [1:0]       err_code
);

   localparam int unsigned      MATCH_W   = $clog2(LOCK_N + 1);
   localparam logic [CNT_W-1:0] c_ONES    = '1;
   localparam logic [CNT_W-1:0] c_EXP_RUN = CNT_W'(EXP_RUN);
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [MATCH_W-1:0] c_LOCK_N = MATCH_W'(LOCK_N);

   logic               edge_det;
   logic               run_ok;
   logic               stall;

   state_e             state_q,    state_d;
   err_code_e          err_code_q, err_code_d;
   logic [CNT_W-1:0]   run_cnt_q,  run_cnt_d;
   logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]   run_len_q,  run_len_d;
   logic [MATCH_W-1:0] match_q,    match_d;
   logic [MATCH_W-1:0] match_inc;
   logic               locked_q;
   logic               err_q;

   toggle_mon_edge u_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (in_sig),
      .edge_o (edge_det)
   );

   assign run_ok    = (run_cnt_q == c_EXP_RUN);
   assign stall     = (run_cnt_q == c_TIMEOUT);
   assign match_inc = match_q + MATCH_W'(1);

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code_q;
      match_d    = match_q;

      run_cnt_d  = run_cnt_q;
      if (edge_det) begin
         run_cnt_d = CNT_W'(1);
      end else if (run_cnt_q != c_ONES) begin
         run_cnt_d = run_cnt_q + CNT_W'(1);
      end

      edge_cnt_d = edge_cnt_q;
      if (edge_det && (edge_cnt_q != c_ONES)) begin
         edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end

      // The offending run is still captured; only later runs are frozen out.
      run_len_d = run_len_q;
      if (edge_det && (state_q != ST_ERROR)) begin
         run_len_d = run_cnt_q;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (edge_det) begin
               state_d = ST_TRACK;
               match_d = '0;
            end
         end
         ST_TRACK: begin
            if (edge_det) begin
               if (run_ok) begin
                  match_d = match_inc;
                  if (match_inc == c_LOCK_N) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_RUN;
               end
            end else if (stall) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_STALL;
            end
         end
         ST_LOCKED: begin
            if (edge_det) begin
               if (!run_ok) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_RUN;
               end
            end else if (stall) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_STALL;
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clr) begin
         state_d    = ST_IDLE;
         err_code_d = ERR_NONE;
         match_d    = '0;
         run_cnt_d  = '0;
         edge_cnt_d = '0;
         run_len_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         err_code_q <= ERR_NONE;
         match_q    <= '0;
         run_cnt_q  <= '0;
         edge_cnt_q <= '0;
         run_len_q  <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_code_q <= err_code_d;
         match_q    <= match_d;
         run_cnt_q  <= run_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         run_len_q  <= run_len_d;
         locked_q   <= (state_d == ST_LOCKED);
         err_q      <= (state_d == ST_ERROR);
      end
   end

   assign edge_cnt = edge_cnt_q;
   assign run_len  = run_len_q;
   assign locked   = locked_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

`default_nettype wire
